// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts one instruction at a time over a valid/ready
// handshake, decodes its opcode into ALU controls, holds those controls for
// an opcode-dependent number of EXEC cycles and then pulses write-back.
// Undefined opcodes are consumed and reported with a one-cycle illegal_op pulse.
module alu_op_sequencer #(
    parameter int INSTR_W = 16,
    parameter int OPC_W   = 3,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr,
    output logic               instr_ready,
    input  logic               abort,
    output logic [2:0]         op_select,
    output logic               sub,
    output logic               alu_en,
    output logic               wb_valid,
    output logic               illegal_op,
    output logic               busy
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [2:0]       op_next;
    logic             sub_next;
    logic             illegal_next;

    logic [OPC_W-1:0] opcode;
    logic             dec_legal;
    logic [2:0]       dec_op;
    logic             dec_sub;
    logic [CNT_W-1:0] dec_lat;
    logic             handshake;

    // Only the opcode field matters; the operand bits are routed elsewhere.
    logic             unused_instr_bits;

    assign opcode            = instr[INSTR_W-1 -: OPC_W];
    assign unused_instr_bits = ^instr;
    assign handshake         = instr_valid && instr_ready;

    // The sequencer can take a new instruction whenever it is not executing.
    assign instr_ready = (state != EXEC);
    assign alu_en      = (state == EXEC);
    assign busy        = (state == EXEC);
    assign wb_valid    = (state == DONE);

    // Opcode decode; the full opcode field is compared so upper bits must be zero.
    always_comb begin
        dec_legal = 1'b1;
        dec_op    = 3'b000;
        dec_sub   = 1'b0;
        dec_lat   = CNT_W'(1);
        case (opcode)
            OPC_W'(0): dec_op = 3'b000;
            OPC_W'(1): dec_sub = 1'b1;
            OPC_W'(2): dec_op = 3'b010;
            OPC_W'(3): dec_op = 3'b011;
            OPC_W'(4): begin
                dec_op  = 3'b100;
                dec_lat = CNT_W'(MUL_LAT);
            end
            OPC_W'(5): begin
                dec_op  = 3'b101;
                dec_lat = CNT_W'(DIV_LAT);
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Next-state logic: acceptance in IDLE/DONE, countdown and abort in EXEC.
    always_comb begin
        state_next   = state;
        count_next   = count;
        op_next      = op_select;
        sub_next     = sub;
        illegal_next = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (handshake && dec_legal) begin
                    state_next = EXEC;
                    count_next = dec_lat;
                    op_next    = dec_op;
                    sub_next   = dec_sub;
                end else begin
                    state_next   = IDLE;
                    illegal_next = handshake;
                end
            end
            EXEC: begin
                if (abort) begin
                    state_next = IDLE;
                    count_next = '0;
                end else if (count == CNT_W'(1)) begin
                    state_next = DONE;
                    count_next = '0;
                end else begin
                    count_next = count - CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    // State, counter and registered ALU controls with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            op_select  <= 3'b000;
            sub        <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            op_select  <= op_next;
            sub        <= sub_next;
            illegal_op <= illegal_next;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: the stimulus task queues the expected
// write-back / illegal_op event (cycle, controls, EXEC length) for every
// accepted instruction, and a negedge monitor pops and compares whenever the
// DUT raises wb_valid or illegal_op.
module tb_alu_op_sequencer;

    typedef struct {
        bit         is_wb;
        int         cyc;
        logic [2:0] op;
        logic       sub;
        int         lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic        abort;
    logic [2:0]  op_select;
    logic        sub;
    logic        alu_en;
    logic        wb_valid;
    logic        illegal_op;
    logic        busy;

    logic        instr_valid4;
    logic [15:0] instr4;
    logic        instr_ready4;
    logic        abort4;
    logic [2:0]  op_select4;
    logic        sub4;
    logic        alu_en4;
    logic        wb_valid4;
    logic        illegal_op4;
    logic        busy4;

    int          checks = 0;
    int          passes = 0;
    int          cyc = 0;
    bit          mon_on = 1'b0;
    int          run_len = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    logic [2:0]  model_op = 3'b000;
    logic        model_sub = 1'b0;

    alu_op_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_ready(instr_ready),
        .abort      (abort),
        .op_select  (op_select),
        .sub        (sub),
        .alu_en     (alu_en),
        .wb_valid   (wb_valid),
        .illegal_op (illegal_op),
        .busy       (busy)
    );

    alu_op_sequencer #(.OPC_W(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr_valid(instr_valid4),
        .instr      (instr4),
        .instr_ready(instr_ready4),
        .abort      (abort4),
        .op_select  (op_select4),
        .sub        (sub4),
        .alu_en     (alu_en4),
        .wb_valid   (wb_valid4),
        .illegal_op (illegal_op4),
        .busy       (busy4)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle index: after accept edge N the DUT is in cycle N.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Offers one instruction from a negedge, waits for acceptance and queues the expected event.
    task automatic applyStimulus(input logic [2:0] opc, input bit legal, input logic [2:0] e_op,
                                 input logic e_sub, input int e_lat, input bit expect_out);
        int   waited;
        exp_t e;
        waited      = 0;
        instr_valid = 1'b1;
        instr       = {opc, 13'h0};
        while (!instr_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!instr_ready) begin
            checkOutput("accept_timeout", 32'(instr_ready), 32'd1);
            instr_valid = 1'b0;
            return;
        end
        if (legal) begin
            model_op  = e_op;
            model_sub = e_sub;
        end
        e.is_wb = legal;
        e.cyc   = cyc + 1 + (legal ? e_lat : 0);
        e.op    = model_op;
        e.sub   = model_sub;
        e.lat   = e_lat;
        if (expect_out) sb.push_back(e);
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    // Monitor: protocol invariants every cycle, scoreboard pop on every output event.
    always @(negedge clk) begin
        if (mon_on) begin
            checkOutput("invariants", {28'd0, wb_valid && illegal_op, alu_en && wb_valid,
                                       busy != alu_en, instr_ready == alu_en}, 32'd0);
            if (alu_en) run_len++;
            if (wb_valid || illegal_op) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_output", {30'd0, wb_valid, illegal_op}, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("event_kind_ctrl", {27'd0, wb_valid, illegal_op, op_select, sub},
                                {27'd0, mon_e.is_wb, !mon_e.is_wb, mon_e.op, mon_e.sub});
                    checkOutput("event_cycle", cyc, mon_e.cyc);
                    if (mon_e.is_wb) checkOutput("alu_en_len", run_len, mon_e.lat);
                end
            end
            if (!alu_en) run_len = 0;
        end
    end

    // Directed sequence.
    initial begin
        rst_n        = 1'b0;
        instr_valid  = 1'b0;
        instr        = 16'h0;
        abort        = 1'b0;
        instr_valid4 = 1'b0;
        instr4       = 16'h0;
        abort4       = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_state", {25'd0, op_select, sub, alu_en, busy, wb_valid, illegal_op, instr_ready},
                    {25'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        rst_n  = 1'b1;
        mon_on = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_reset", 32'(instr_ready), 32'd1);

        applyStimulus(3'd0, 1'b1, 3'b000, 1'b0, 1, 1'b1);
        applyStimulus(3'd1, 1'b1, 3'b000, 1'b1, 1, 1'b1);
        applyStimulus(3'd2, 1'b1, 3'b010, 1'b0, 1, 1'b1);
        applyStimulus(3'd3, 1'b1, 3'b011, 1'b0, 1, 1'b1);
        applyStimulus(3'd4, 1'b1, 3'b100, 1'b0, 4, 1'b1);

        // DIV aborted in its 7th EXEC cycle.
        applyStimulus(3'd5, 1'b1, 3'b101, 1'b0, 16, 1'b0);
        repeat (6) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort7_idle", {26'd0, busy, instr_ready, wb_valid, op_select, sub},
                    {26'd0, 1'b0, 1'b1, 1'b0, 3'b101, 1'b0});

        // DIV aborted on its final EXEC cycle: abort beats completion.
        applyStimulus(3'd5, 1'b1, 3'b101, 1'b0, 16, 1'b0);
        repeat (15) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort16_idle", {26'd0, busy, instr_ready, wb_valid, op_select, sub},
                    {26'd0, 1'b0, 1'b1, 1'b0, 3'b101, 1'b0});

        // Consecutive illegal opcodes leave the controls untouched.
        applyStimulus(3'd6, 1'b0, 3'b000, 1'b0, 0, 1'b1);
        applyStimulus(3'd7, 1'b0, 3'b000, 1'b0, 0, 1'b1);
        @(negedge clk);
        checkOutput("illegal_keeps_ctrl", {27'd0, alu_en, op_select, sub}, {27'd0, 1'b0, 3'b101, 1'b0});

        // Illegal opcode accepted in the DONE cycle of an ADD.
        applyStimulus(3'd0, 1'b1, 3'b000, 1'b0, 1, 1'b1);
        applyStimulus(3'd7, 1'b0, 3'b000, 1'b0, 0, 1'b1);

        // Reset during the third MUL EXEC cycle discards the operation.
        applyStimulus(3'd4, 1'b1, 3'b100, 1'b0, 4, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("reset_mid_exec", {25'd0, op_select, sub, alu_en, busy, wb_valid, illegal_op, instr_ready},
                    {25'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        rst_n     = 1'b1;
        model_op  = 3'b000;
        model_sub = 1'b0;
        repeat (6) @(negedge clk);

        applyStimulus(3'd1, 1'b1, 3'b000, 1'b1, 1, 1'b1);

        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        checkOutput("scoreboard_drained", sb.size(), 32'd0);

        // Four-bit opcode instance: 1000b is illegal, 0100b is MUL.
        instr_valid4 = 1'b1;
        instr4       = 16'h8000;
        @(negedge clk);
        checkOutput("opc4_1000_illegal", {27'd0, illegal_op4, alu_en4, op_select4}, {27'd0, 1'b1, 1'b0, 3'b000});
        instr4 = 16'h4000;
        @(negedge clk);
        instr_valid4 = 1'b0;
        checkOutput("opc4_0100_mul", {27'd0, illegal_op4, alu_en4, op_select4}, {27'd0, 1'b0, 1'b1, 3'b100});

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
